// File: rtl/rfid_pkg.sv
// Shared constants, state types and helpers for the RFID reader response receiver.
// The optional checksum comparison is enabled with the RFID_RX_CHKSUM_EN macro.
package rfid_pkg;

   localparam int OVERSAMPLE    = 16;
   localparam int MAX_PL        = 64;
   localparam int TIMEOUT_TICKS = 4096;

   localparam logic [7:0]  RFID_HDR         = 8'hBB;
   localparam logic [7:0]  RFID_END         = 8'h7E;
   localparam logic [7:0]  RFID_TYPE_NOTIFY = 8'h02;
   localparam logic [7:0]  RFID_CMD_POLL    = 8'h22;
   localparam logic [15:0] RFID_PL_NOTIFY   = 16'h0011;

   typedef enum logic [2:0] {
      ST_HUNT, ST_TYPE, ST_CMD, ST_PLH, ST_PLL, ST_PARAM, ST_CHK, ST_END
   } rfid_state_t;

   typedef enum logic [1:0] {
      RX_IDLE, RX_START, RX_DATA, RX_STOP
   } rx_state_t;

   function automatic logic is_notify(input logic [7:0] typ, input logic [7:0] cmd,
                                      input logic [15:0] pl);
      return (typ == RFID_TYPE_NOTIFY) && (cmd == RFID_CMD_POLL) && (pl == RFID_PL_NOTIFY);
   endfunction

endpackage

// File: rtl/rfid_resp_rx_uart.sv
// 8N1 UART byte receiver: 2-flop synchronizer, 16x oversampling with mid-bit sampling.
// Emits one-cycle byte_vld on a good stop bit and one-cycle stop_err on a bad one.
module uart_rx_byte
   import rfid_pkg::*;
(
   input  logic       clk_24M,
   input  logic       rst,
   input  logic       i_tick,
   input  logic       i_rxd,
   output logic [7:0] o_byte_data,
   output logic       o_byte_vld,
   output logic       o_stop_err
);
   localparam logic [3:0] OS_LAST  = 4'(OVERSAMPLE - 1);
   localparam logic [3:0] MID_LAST = 4'(OVERSAMPLE / 2 - 1);

   logic [1:0] r_sync;
   logic       w_rxd;
   rx_state_t  r_state;
   logic [3:0] r_tick_cnt;
   logic [2:0] r_bit_cnt;
   logic [7:0] r_shift;
   logic       r_byte_vld;
   logic       r_stop_err;

   assign w_rxd       = r_sync[1];
   assign o_byte_data = r_shift;
   assign o_byte_vld  = r_byte_vld;
   assign o_stop_err  = r_stop_err;

   // Bring the asynchronous line into the clock domain; idles high.
   always_ff @(posedge clk_24M or negedge rst) begin
      if (!rst) r_sync <= 2'b11;
      else      r_sync <= {r_sync[0], i_rxd};
   end

   // Bit-level receive FSM, advancing only on oversampling ticks.
   always_ff @(posedge clk_24M or negedge rst) begin
      if (!rst) begin
         r_state    <= RX_IDLE;
         r_tick_cnt <= 4'd0;
         r_bit_cnt  <= 3'd0;
         r_shift    <= 8'h00;
         r_byte_vld <= 1'b0;
         r_stop_err <= 1'b0;
      end else begin
         r_byte_vld <= 1'b0;
         r_stop_err <= 1'b0;
         if (i_tick) begin
            case (r_state)
               RX_IDLE: begin
                  r_tick_cnt <= 4'd0;
                  if (!w_rxd) r_state <= RX_START;
                  else        r_state <= RX_IDLE;
               end
               RX_START: begin
                  if (r_tick_cnt == MID_LAST) begin
                     // A start bit that is high again at mid-bit was only a glitch.
                     r_tick_cnt <= 4'd0;
                     r_bit_cnt  <= 3'd0;
                     r_state    <= w_rxd ? RX_IDLE : RX_DATA;
                  end else begin
                     r_tick_cnt <= r_tick_cnt + 4'd1;
                  end
               end
               RX_DATA: begin
                  if (r_tick_cnt == OS_LAST) begin
                     r_tick_cnt <= 4'd0;
                     r_shift    <= {w_rxd, r_shift[7:1]};
                     if (r_bit_cnt == 3'd7) r_state <= RX_STOP;
                     else                   r_bit_cnt <= r_bit_cnt + 3'd1;
                  end else begin
                     r_tick_cnt <= r_tick_cnt + 4'd1;
                  end
               end
               RX_STOP: begin
                  if (r_tick_cnt == OS_LAST) begin
                     r_tick_cnt <= 4'd0;
                     r_state    <= RX_IDLE;
                     r_byte_vld <= w_rxd;
                     r_stop_err <= !w_rxd;
                  end else begin
                     r_tick_cnt <= r_tick_cnt + 4'd1;
                  end
               end
               default: r_state <= RX_IDLE;
            endcase
         end
      end
   end

endmodule

// File: rtl/rfid_resp_rx.sv
// Reader frame parser: BB|TYPE|CMD|PL_H|PL_L|PARAM|CHK|7E, commits RSSI/EPC of poll notifications.
// Define RFID_RX_CHKSUM_EN to reject frames whose CHK byte does not match the running sum.
module rfid_resp_rx
   import rfid_pkg::*;
(
   input  logic        clk_24M,
   input  logic        rst,
   input  logic        i_baud_tick16,
   input  logic        i_rxd,
   output logic [95:0] o_epc,
   output logic [7:0]  o_rssi,
   output logic        o_tag_valid,
   output logic        o_frame_err,
   output logic        o_busy
);
   localparam int               TMO_W    = $clog2(TIMEOUT_TICKS);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_TICKS - 1);
   localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
   localparam logic [15:0]      PL_MAX   = 16'(MAX_PL);

   logic [7:0]       w_byte;
   logic             w_byte_vld;
   logic             w_stop_err;
   logic [15:0]      w_pl;
   rfid_state_t      r_state;
   logic [7:0]       r_type, r_cmd, r_plh, r_pll;
   logic [6:0]       r_pl_cnt, r_idx;
   logic [95:0]      r_sh_epc, r_epc;
   logic [7:0]       r_sh_rssi, r_rssi;
   logic             r_tag_valid, r_frame_err;
   logic [TMO_W-1:0] r_tmo_cnt;

   uart_rx_byte u_rx (
      .clk_24M     (clk_24M),
      .rst         (rst),
      .i_tick      (i_baud_tick16),
      .i_rxd       (i_rxd),
      .o_byte_data (w_byte),
      .o_byte_vld  (w_byte_vld),
      .o_stop_err  (w_stop_err)
   );

   assign w_pl        = {r_plh, w_byte};
   assign o_epc       = r_epc;
   assign o_rssi      = r_rssi;
   assign o_tag_valid = r_tag_valid;
   assign o_frame_err = r_frame_err;
   assign o_busy      = (r_state != ST_HUNT);

`ifdef RFID_RX_CHKSUM_EN
   logic [7:0] r_sum;

   // Running wrap-around sum over TYPE, CMD, PL_H, PL_L and PARAM bytes.
   always_ff @(posedge clk_24M or negedge rst) begin
      if (!rst)                                  r_sum <= 8'h00;
      else if (w_byte_vld && r_state == ST_TYPE) r_sum <= w_byte;
      else if (w_byte_vld && (r_state inside {ST_CMD, ST_PLH, ST_PLL, ST_PARAM}))
                                                 r_sum <= r_sum + w_byte;
      else                                       r_sum <= r_sum;
   end
`endif

   // Frame parser, shadow capture, commit and inter-byte timeout.
   always_ff @(posedge clk_24M or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_HUNT;
         r_type      <= 8'h00;
         r_cmd       <= 8'h00;
         r_plh       <= 8'h00;
         r_pll       <= 8'h00;
         r_pl_cnt    <= 7'd0;
         r_idx       <= 7'd0;
         r_sh_epc    <= 96'd0;
         r_sh_rssi   <= 8'h00;
         r_epc       <= 96'd0;
         r_rssi      <= 8'h00;
         r_tag_valid <= 1'b0;
         r_frame_err <= 1'b0;
         r_tmo_cnt   <= '0;
      end else begin
         r_tag_valid <= 1'b0;
         r_frame_err <= 1'b0;
         if (w_stop_err) begin
            r_frame_err <= 1'b1;
            r_state     <= ST_HUNT;
            r_tmo_cnt   <= '0;
         end else if (w_byte_vld) begin
            // A byte always wins over the timeout, so a header arriving at the limit is kept.
            r_tmo_cnt <= '0;
            case (r_state)
               ST_HUNT:  r_state <= (w_byte == RFID_HDR) ? ST_TYPE : ST_HUNT;
               ST_TYPE: begin r_type <= w_byte; r_state <= ST_CMD; end
               ST_CMD:  begin r_cmd  <= w_byte; r_state <= ST_PLH; end
               ST_PLH:  begin r_plh  <= w_byte; r_state <= ST_PLL; end
               ST_PLL: begin
                  r_pll    <= w_byte;
                  r_pl_cnt <= w_byte[6:0];
                  r_idx    <= 7'd0;
                  if (w_pl == 16'd0) begin
                     r_state <= ST_CHK;
                  end else if (w_pl > PL_MAX) begin
                     r_frame_err <= 1'b1;
                     r_state     <= ST_HUNT;
                  end else begin
                     r_state <= ST_PARAM;
                  end
               end
               ST_PARAM: begin
                  // PARAM[0] is RSSI, PARAM[3..14] the EPC; PC and CRC are skipped.
                  if (r_idx == 7'd0) r_sh_rssi <= w_byte;
                  if (r_idx >= 7'd3 && r_idx <= 7'd14) r_sh_epc <= {r_sh_epc[87:0], w_byte};
                  r_idx <= r_idx + 7'd1;
                  if (r_idx == r_pl_cnt - 7'd1) r_state <= ST_CHK;
                  else                          r_state <= ST_PARAM;
               end
               ST_CHK: begin
`ifdef RFID_RX_CHKSUM_EN
                  if (w_byte != r_sum) begin
                     r_frame_err <= 1'b1;
                     r_state     <= ST_HUNT;
                  end else begin
                     r_state <= ST_END;
                  end
`else
                  r_state <= ST_END;
`endif
               end
               ST_END: begin
                  r_state <= ST_HUNT;
                  if (w_byte != RFID_END) begin
                     r_frame_err <= 1'b1;
                  end else if (is_notify(r_type, r_cmd, {r_plh, r_pll})) begin
                     r_epc       <= r_sh_epc;
                     r_rssi      <= r_sh_rssi;
                     r_tag_valid <= 1'b1;
                  end
               end
               default: r_state <= ST_HUNT;
            endcase
         end else if (r_state == ST_HUNT) begin
            r_tmo_cnt <= '0;
         end else if (i_baud_tick16) begin
            if (r_tmo_cnt == TMO_LAST) begin
               r_frame_err <= 1'b1;
               r_state     <= ST_HUNT;
               r_tmo_cnt   <= '0;
            end else begin
               r_tmo_cnt <= r_tmo_cnt + TMO_ONE;
            end
         end
      end
   end

endmodule
